// File: rtl/victim_cache_pkg.sv
// Shared types for the victim-cache memory-side logic.
// Covers the arbiter FSM states and the requester identifiers.
package victim_cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } arb_state_t;

   typedef logic req_id_t;

   localparam req_id_t REQ_L1     = 1'b0;
   localparam req_id_t REQ_VICTIM = 1'b1;

endpackage

// File: rtl/mux2_1.sv
// Single-bit 2:1 multiplexer used to build the request-side command muxes.
// s=0 selects a, s=1 selects b.
module mux2_1 (
   input  logic a,
   input  logic b,
   input  logic s,
   output logic y
);

   assign y = s ? b : a;

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin pick.
// On a tie, the requester that was not served last wins.
module rr_arb2
   import victim_cache_pkg::*;
(
   input  logic    req0,
   input  logic    req1,
   input  req_id_t last,
   output logic    valid,
   output req_id_t id
);

   always_comb begin
      valid = req0 | req1;
      if (req0 && req1) begin
         id = ~last;
      end else if (req1) begin
         id = REQ_VICTIM;
      end else begin
         id = REQ_L1;
      end
   end

endmodule

// File: rtl/victim_mem_arbiter.sv
// Shares one lower-level memory port between the L1 fill path (req0) and the
// victim writeback path (req1), one transaction at a time, with a wait timeout.
module victim_mem_arbiter
   import victim_cache_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic              sel,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int CMD_W = 1 + ADDR_W + DATA_W;

   arb_state_t       state;
   arb_state_t       next_state;
   req_id_t          last;
   req_id_t          grant_id;
   logic             grant_valid;
   logic [CNT_W-1:0] cnt;
   logic             timeout_hit;
   logic [CMD_W-1:0] cmd0;
   logic [CMD_W-1:0] cmd1;
   logic [CMD_W-1:0] cmd_win;

   rr_arb2 u_arb (
      .req0  (req0),
      .req1  (req1),
      .last  (last),
      .valid (grant_valid),
      .id    (grant_id)
   );

   assign cmd0 = {we0, addr0, wdata0};
   assign cmd1 = {we1, addr1, wdata1};

   for (genvar i = 0; i < CMD_W; i++) begin : g_cmd_mux
      mux2_1 u_mux (
         .a (cmd0[i]),
         .b (cmd1[i]),
         .s (grant_id),
         .y (cmd_win[i])
      );
   end

   // A completing mem_ack in the last allowed cycle beats the timeout.
   assign timeout_hit = !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      // NOTE: default assigned first so no path through the case leaves next_state unassigned (no latch).
      next_state = state;
      case (state)
         IDLE:    if (grant_valid) next_state = WAIT;
         WAIT:    if (mem_ack || timeout_hit) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      ack0 = 1'b0;
      ack1 = 1'b0;
      if (state == DONE) begin
         ack0 = (sel == REQ_L1);
         ack1 = (sel == REQ_VICTIM);
      end
   end

   // NOTE: non-blocking assignments so every register here samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel       <= REQ_L1;
         last      <= REQ_VICTIM;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cnt       <= '0;
         rdata     <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  sel                            <= grant_id;
                  last                           <= grant_id;
                  {mem_we, mem_addr, mem_wdata}  <= cmd_win;
                  mem_req                        <= 1'b1;
                  cnt                            <= '0;
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  rdata   <= mem_rdata;
                  err     <= 1'b0;
                  mem_req <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (timeout_hit) begin
                     rdata   <= '0;
                     err     <= 1'b1;
                     mem_req <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
